// File: rtl/dll_mon_pkg.sv
// rtl/dll_mon_pkg.sv - shared DLL monitor FSM states and default parameters
package dll_mon_pkg;

  localparam int DEF_CODE_WIDTH = 8;
  localparam int DEF_THRESH     = 2;
  localparam int DEF_SAMPLE_DIV = 64;
  localparam int DEF_FILT_CNT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DIFF  = 2'd2
  } dll_mon_state_e;

endpackage

// File: rtl/dll_code_absdiff.sv
// rtl/dll_code_absdiff.sv - unsigned |a - b| of two delay codes with threshold compare
module dll_code_absdiff
  import dll_mon_pkg::*;
#(
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  parameter int THRESH     = DEF_THRESH
) (
  input  logic [CODE_WIDTH-1:0] code_a,
  input  logic [CODE_WIDTH-1:0] code_b,
  output logic [CODE_WIDTH-1:0] diff,
  output logic                  over_thresh
);

  localparam logic [CODE_WIDTH-1:0] THRESH_C = CODE_WIDTH'(THRESH);

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    if (code_a >= code_b) begin
      diff = code_a - code_b;
    end else begin
      diff = code_b - code_a;
    end
    over_thresh = (diff > THRESH_C);
  end

endmodule

// File: rtl/dll_dly_diff_det.sv
// rtl/dll_dly_diff_det.sv - DLL delay-code drift detector: periodic stable sampling,
// deviation filter and sticky drift flag cleared by code_update or loss of lock.
module dll_dly_diff_det
  import dll_mon_pkg::*;
#(
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  parameter int THRESH     = DEF_THRESH,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int FILT_CNT   = DEF_FILT_CNT
) (
  input  logic                  SCLK,
  input  logic                  reset_n,
  input  logic                  dll_lock,
  input  logic [CODE_WIDTH-1:0] dll_code,
  input  logic                  code_update,
  output logic                  dll_dly_diff,
  output logic [CODE_WIDTH-1:0] dly_diff_mag
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int FW = (FILT_CNT > 0) ? $clog2(FILT_CNT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILT_CNT);

  dll_mon_state_e        state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [CODE_WIDTH-1:0] ref_q, ref_d;
  logic [CODE_WIDTH-1:0] last_q, last_d;
  logic [CODE_WIDTH-1:0] mag_q, mag_d;
  logic [CODE_WIDTH-1:0] prev_code_q;
  logic                  flag_q, flag_d;

  logic [CODE_WIDTH-1:0] diff;
  logic                  over_thresh;
  logic                  sample_pt;
  logic                  upd_take;

  dll_code_absdiff #(
    .CODE_WIDTH (CODE_WIDTH),
    .THRESH     (THRESH)
  ) u_absdiff (
    .code_a      (dll_code),
    .code_b      (ref_q),
    .diff        (diff),
    .over_thresh (over_thresh)
  );

  // A sample is only trusted if the code held still across the last two cycles.
  assign sample_pt = (timer_q == TIMER_LAST) && (dll_code == prev_code_q);
  assign upd_take  = code_update && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    filt_d  = filt_q;
    ref_d   = ref_q;
    last_d  = last_q;
    mag_d   = mag_q;
    flag_d  = flag_q;

    if (!dll_lock) begin
      state_d = ST_IDLE;
      timer_d = '0;
      filt_d  = '0;
      flag_d  = 1'b0;
    end else begin
      timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;

      if (upd_take) begin
        state_d = ST_TRACK;
        ref_d   = last_q;
        filt_d  = '0;
        flag_d  = 1'b0;
      end else if (sample_pt) begin
        last_d = dll_code;
        case (state_q)
          ST_IDLE: begin
            ref_d   = dll_code;
            mag_d   = '0;
            filt_d  = '0;
            state_d = ST_TRACK;
          end
          ST_TRACK: begin
            mag_d = diff;
            if (over_thresh) begin
              filt_d = filt_q + 1'b1;
              if (filt_d == FILT_MAX) begin
                state_d = ST_DIFF;
                flag_d  = 1'b1;
              end
            end else begin
              filt_d = '0;
            end
          end
          ST_DIFF: begin
            mag_d = diff;
            if (!over_thresh) begin
              filt_d = '0;
            end else if (filt_q != FILT_MAX) begin
              filt_d = filt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      filt_q      <= '0;
      ref_q       <= '0;
      last_q      <= '0;
      mag_q       <= '0;
      prev_code_q <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      filt_q      <= filt_d;
      ref_q       <= ref_d;
      last_q      <= last_d;
      mag_q       <= mag_d;
      prev_code_q <= dll_code;
      flag_q      <= flag_d;
    end
  end

  assign dll_dly_diff = flag_q;
  assign dly_diff_mag = mag_q;

endmodule
